// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: FU count, tag width, CDB packet types
// and the round-robin pointer advance.
package cdb_arbiter_pkg;

    localparam int NUM_FU   = 5;
    localparam int T_W      = 6;
    localparam int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Functional unit order; index i of every fu_* vector is this list's entry i.
    typedef enum logic [FU_IDX_W-1:0] {
        FU_ALU0   = 3'd0,
        FU_ALU1   = 3'd1,
        FU_MULT   = 3'd2,
        FU_LOAD   = 3'd3,
        FU_BRANCH = 3'd4
    } FU_LIST_e;

    typedef struct packed {
        logic              valid;
        logic [T_W-1:0]    T_idx;
        logic [NUM_FU-1:0] fu_onehot;
    } CDB_PACKET_t;

    typedef struct packed {
        logic [NUM_FU-1:0]     fu_valid;
        logic [NUM_FU*T_W-1:0] fu_T;
    } CDB_ARB_IN_t;

    typedef struct packed {
        logic [NUM_FU-1:0] fu_ready;
        CDB_PACKET_t       cdb;
    } CDB_ARB_OUT_t;

    // Pointer moves one past the winner, wrapping at the last FU.
    function automatic logic [FU_IDX_W-1:0] next_ptr(input logic [FU_IDX_W-1:0] w);
        return (w == FU_IDX_W'(NUM_FU - 1)) ? '0 : w + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The request vector is doubled and the
// copy below ptr is masked off, so the lowest remaining set bit is the first
// requester at or after ptr, wrapping through the upper copy.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic [2*N-1:0] mask;
    logic [2*N-1:0] req_dbl;
    logic           found;

    generate
        for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
            assign mask[gi] = (gi >= int'(ptr));
        end
    endgenerate

    assign req_dbl = {req, req} & mask;

    // Lowest set bit of the masked doubled vector, folded back to an FU index.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        for (int k = 0; k < 2*N; k++) begin
            if (!found && req_dbl[k]) begin
                found  = 1'b1;
                winner = PW'(k % N);
            end
        end
        if (found) begin
            grant = {{(N-1){1'b0}}, 1'b1} << winner;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per FU, round-robin grant of one
// slot per cycle, registered broadcast of the winning tag.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic [NUM_FU-1:0]     fu_valid,
    input  logic [NUM_FU*T_W-1:0] fu_T,
    output logic [NUM_FU-1:0]     fu_ready,
    output logic                  cdb_valid,
    output logic [T_W-1:0]        cdb_T,
    output logic [NUM_FU-1:0]     cdb_fu
);

    logic [NUM_FU-1:0]   hold_v;
    logic [NUM_FU-1:0]   hold_v_next;
    logic [T_W-1:0]      hold_T      [NUM_FU];
    logic [T_W-1:0]      hold_T_next [NUM_FU];
    logic [FU_IDX_W-1:0] rr_ptr;
    logic [NUM_FU-1:0]   grant;
    logic [FU_IDX_W-1:0] winner;
    logic [NUM_FU-1:0]   accept;
    CDB_PACKET_t         cdb_reg;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req    (hold_v),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // A granted slot empties this cycle, so it may take a new tag at the same edge.
    // Reset is folded in so producers see no ready while it is asserted.
    assign fu_ready = {NUM_FU{reset & en & ~flush}} & (~hold_v | grant);
    assign accept   = fu_valid & fu_ready;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
            assign hold_v_next[gi] = accept[gi] | (hold_v[gi] & ~grant[gi]);
            assign hold_T_next[gi] = accept[gi] ? fu_T[gi*T_W +: T_W] : hold_T[gi];
        end
    endgenerate

    // Holding slots: load on accept, drain on grant, squash on flush, freeze when en is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_v <= '0;
            for (int i = 0; i < NUM_FU; i++) hold_T[i] <= '0;
        end else if (en) begin
            hold_v <= flush ? '0 : hold_v_next;
            for (int i = 0; i < NUM_FU; i++) hold_T[i] <= hold_T_next[i];
        end
    end

    // Round-robin pointer and registered CDB broadcast of the winner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            cdb_reg <= '0;
        end else if (en) begin
            if (flush) begin
                rr_ptr            <= '0;
                cdb_reg.valid     <= 1'b0;
                cdb_reg.fu_onehot <= '0;
            end else begin
                if (|grant) rr_ptr <= next_ptr(winner);
                cdb_reg.valid     <= |grant;
                cdb_reg.T_idx     <= hold_T[winner];
                cdb_reg.fu_onehot <= grant;
            end
        end
    end

    assign cdb_valid = cdb_reg.valid;
    assign cdb_T     = cdb_reg.T_idx;
    assign cdb_fu    = cdb_reg.fu_onehot;

endmodule
